// File: rtl/ex_mem_stage.sv
// ex_mem_stage: Y86 execute stage fused with the EX/MEM pipeline register.
// Computes valE with the ALU, keeps the condition-code register (ZF/SF/OF),
// evaluates Cnd for jXX/cmovXX, resolves dstE/dstM and registers the
// result toward the memory stage.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_icode..ex_valP         id_ex register outputs
//   mem_stall                 hold the EX/MEM register and the CC register
//   mem_bubble                load a nop into the EX/MEM register
//   set_cc_inhibit            block the CC update (downstream exception)
//   ex_cnd                    combinational Cnd (icode 2/7 only)
//   mem_*                     registered EX/MEM outputs
//   cc_zf, cc_sf, cc_of       condition-code register
module ex_mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_icode,
  input  logic [7:0]  ex_ifun,
  input  logic [7:0]  ex_rA,
  input  logic [7:0]  ex_rB,
  input  logic [31:0] ex_valA,
  input  logic [31:0] ex_valB,
  input  logic [31:0] ex_valC,
  input  logic [31:0] ex_valP,
  input  logic        mem_stall,
  input  logic        mem_bubble,
  input  logic        set_cc_inhibit,
  output logic        ex_cnd,
  output logic [7:0]  mem_icode,
  output logic [7:0]  mem_ifun,
  output logic        mem_cnd,
  output logic [31:0] mem_valE,
  output logic [31:0] mem_valA,
  output logic [7:0]  mem_dstE,
  output logic [7:0]  mem_dstM,
  output logic [31:0] mem_valP,
  output logic        cc_zf,
  output logic        cc_sf,
  output logic        cc_of
);
  localparam logic [7:0] RNONE = 8'h0F;
  localparam logic [7:0] RESP  = 8'h04;

  logic [31:0] alu_a, alu_b, val_e;
  logic [7:0]  dst_e, dst_m;
  logic        is_opl, op_ok, set_cc, cnd_raw;
  logic        nzf, nsf, nof;

  assign is_opl = (ex_icode == 8'h06);
  assign op_ok  = (ex_ifun <= 8'd3);

  // ALU operand select
  always_comb begin
    alu_a = 32'h0;
    alu_b = 32'h0;
    case (ex_icode)
      8'h02, 8'h06:        alu_a = ex_valA;
      8'h03, 8'h04, 8'h05: alu_a = ex_valC;
      8'h08, 8'h0A:        alu_a = 32'hFFFF_FFFC;
      8'h09, 8'h0B:        alu_a = 32'd4;
      default:             alu_a = 32'h0;
    endcase
    case (ex_icode)
      8'h04, 8'h05, 8'h06, 8'h08, 8'h09, 8'h0A, 8'h0B: alu_b = ex_valB;
      default:                                        alu_b = 32'h0;
    endcase
  end

  // ALU and the flags an OPl would write
  always_comb begin
    val_e = alu_b + alu_a;
    nof   = (alu_a[31] == alu_b[31]) && (val_e[31] != alu_a[31]);
    if (is_opl) begin
      case (ex_ifun)
        8'd0: ;
        8'd1: begin
          val_e = alu_b - alu_a;
          nof   = (alu_a[31] != alu_b[31]) && (val_e[31] != alu_b[31]);
        end
        8'd2: begin val_e = alu_b & alu_a; nof = 1'b0; end
        8'd3: begin val_e = alu_b ^ alu_a; nof = 1'b0; end
        default: begin val_e = 32'h0; nof = 1'b0; end
      endcase
    end
    nzf = (val_e == 32'h0);
    nsf = val_e[31];
  end

  assign set_cc = is_opl && op_ok && !set_cc_inhibit;

  // Cnd from the current (pre-update) flags
  always_comb begin
    cnd_raw = 1'b0;
    case (ex_ifun)
      8'd0: cnd_raw = 1'b1;
      8'd1: cnd_raw = (cc_sf ^ cc_of) | cc_zf;
      8'd2: cnd_raw = cc_sf ^ cc_of;
      8'd3: cnd_raw = cc_zf;
      8'd4: cnd_raw = !cc_zf;
      8'd5: cnd_raw = !(cc_sf ^ cc_of);
      8'd6: cnd_raw = !(cc_sf ^ cc_of) && !cc_zf;
      default: cnd_raw = 1'b0;
    endcase
  end

  assign ex_cnd = ((ex_icode == 8'h02) || (ex_icode == 8'h07)) && cnd_raw;

  always_comb begin
    dst_e = RNONE;
    case (ex_icode)
      8'h02:                      dst_e = cnd_raw ? ex_rB : RNONE;
      8'h03, 8'h06:               dst_e = ex_rB;
      8'h08, 8'h09, 8'h0A, 8'h0B: dst_e = RESP;
      default:                    dst_e = RNONE;
    endcase
    dst_m = ((ex_icode == 8'h05) || (ex_icode == 8'h0B)) ? ex_rA : RNONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cc_zf     <= 1'b1;
      cc_sf     <= 1'b0;
      cc_of     <= 1'b0;
      mem_icode <= 8'h01;
      mem_ifun  <= 8'h00;
      mem_cnd   <= 1'b0;
      mem_valE  <= 32'h0;
      mem_valA  <= 32'h0;
      mem_dstE  <= RNONE;
      mem_dstM  <= RNONE;
      mem_valP  <= 32'h0;
    end else if (!mem_stall) begin
      // a bubble kills the EX/MEM load but the OPl flags still land
      if (set_cc) begin
        cc_zf <= nzf;
        cc_sf <= nsf;
        cc_of <= nof;
      end
      if (mem_bubble) begin
        mem_icode <= 8'h01;
        mem_ifun  <= 8'h00;
        mem_cnd   <= 1'b0;
        mem_valE  <= 32'h0;
        mem_valA  <= 32'h0;
        mem_dstE  <= RNONE;
        mem_dstM  <= RNONE;
        mem_valP  <= 32'h0;
      end else begin
        mem_icode <= ex_icode;
        mem_ifun  <= ex_ifun;
        mem_cnd   <= ex_cnd;
        mem_valE  <= val_e;
        mem_valA  <= ex_valA;
        mem_dstE  <= dst_e;
        mem_dstM  <= dst_m;
        mem_valP  <= ex_valP;
      end
    end
  end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed test-plan sequence with
// literal expectations, then randomized stimulus checked every cycle
// against a behavioural model of the stage.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  ex_icode, ex_ifun, ex_rA, ex_rB;
  logic [31:0] ex_valA, ex_valB, ex_valC, ex_valP;
  logic        mem_stall, mem_bubble, set_cc_inhibit;
  logic        ex_cnd, mem_cnd, cc_zf, cc_sf, cc_of;
  logic [7:0]  mem_icode, mem_ifun, mem_dstE, mem_dstM;
  logic [31:0] mem_valE, mem_valA, mem_valP;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ex_mem_stage dut (
    .clk(clk), .rst(rst),
    .ex_icode(ex_icode), .ex_ifun(ex_ifun), .ex_rA(ex_rA), .ex_rB(ex_rB),
    .ex_valA(ex_valA), .ex_valB(ex_valB), .ex_valC(ex_valC), .ex_valP(ex_valP),
    .mem_stall(mem_stall), .mem_bubble(mem_bubble), .set_cc_inhibit(set_cc_inhibit),
    .ex_cnd(ex_cnd), .mem_icode(mem_icode), .mem_ifun(mem_ifun), .mem_cnd(mem_cnd),
    .mem_valE(mem_valE), .mem_valA(mem_valA), .mem_dstE(mem_dstE), .mem_dstM(mem_dstM),
    .mem_valP(mem_valP), .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [7:0]  icode, ifun, dste, dstm;
    logic        cnd;
    logic [31:0] vale, vala, valp;
  } exmem_t;

  exmem_t m;
  logic m_zf, m_sf, m_of;

  // Everything the stage derives from one instruction, given the current flags.
  task automatic model_ex(input logic zf, input logic sf, input logic of_,
                          output exmem_t r, output logic upd,
                          output logic nz, output logic ns, output logic no);
    longint sa, sb, res;
    logic   c;
    int     f;
    f = int'(ex_ifun);
    case (f)
      0: c = 1;
      1: c = (sf != of_) || zf;
      2: c = (sf != of_);
      3: c = zf;
      4: c = !zf;
      5: c = (sf == of_);
      6: c = (sf == of_) && !zf;
      default: c = 0;
    endcase
    r.icode = ex_icode; r.ifun = ex_ifun; r.vala = ex_valA; r.valp = ex_valP;
    r.cnd = (ex_icode == 2 || ex_icode == 7) ? c : 1'b0;
    r.dstm = (ex_icode == 5 || ex_icode == 11) ? ex_rA : 8'h0F;
    r.dste = 8'h0F;
    r.vale = 32'h0;
    upd = 0; nz = 0; ns = 0; no = 0;
    case (int'(ex_icode))
      2:  begin r.vale = ex_valA; r.dste = c ? ex_rB : 8'h0F; end
      3:  begin r.vale = ex_valC; r.dste = ex_rB; end
      4, 5: r.vale = ex_valB + ex_valC;
      8, 10: begin r.vale = ex_valB - 32'd4; r.dste = 8'h04; end
      9, 11: begin r.vale = ex_valB + 32'd4; r.dste = 8'h04; end
      6: begin
        r.dste = ex_rB;
        sa = longint'($signed(ex_valA));
        sb = longint'($signed(ex_valB));
        res = 0;
        case (f)
          0: res = sb + sa;
          1: res = sb - sa;
          2: res = longint'($signed(ex_valB & ex_valA));
          3: res = longint'($signed(ex_valB ^ ex_valA));
          default: res = 0;
        endcase
        r.vale = res[31:0];
        if (f <= 3) begin
          upd = !set_cc_inhibit;
          nz = (r.vale == 0);
          ns = r.vale[31];
          no = (res > 64'sd2147483647) || (res < -64'sd2147483648);
        end
      end
      default: ;
    endcase
  endtask

  function automatic exmem_t nop_val();
    exmem_t r;
    r.icode = 8'h01; r.ifun = 0; r.cnd = 0; r.vale = 0; r.vala = 0;
    r.valp = 0; r.dste = 8'h0F; r.dstm = 8'h0F;
    return r;
  endfunction

  always @(posedge clk) begin
    exmem_t r;
    logic u, nz, ns, no;
    model_ex(m_zf, m_sf, m_of, r, u, nz, ns, no);
    if (rst) begin
      m = nop_val(); m_zf = 1; m_sf = 0; m_of = 0;
    end else if (!mem_stall) begin
      if (u) begin m_zf = nz; m_sf = ns; m_of = no; end
      m = mem_bubble ? nop_val() : r;
    end
  end

  // single compare process, mid-cycle
  always @(negedge clk) begin
    exmem_t r;
    logic u, nz, ns, no;
    if (chk_en) begin
      model_ex(m_zf, m_sf, m_of, r, u, nz, ns, no);
      chk("ex_cnd", {31'b0, ex_cnd}, {31'b0, r.cnd});
      chk("mem_icode", {24'b0, mem_icode}, {24'b0, m.icode});
      chk("mem_ifun", {24'b0, mem_ifun}, {24'b0, m.ifun});
      chk("mem_cnd", {31'b0, mem_cnd}, {31'b0, m.cnd});
      chk("mem_valE", mem_valE, m.vale);
      chk("mem_valA", mem_valA, m.vala);
      chk("mem_valP", mem_valP, m.valp);
      chk("mem_dstE", {24'b0, mem_dstE}, {24'b0, m.dste});
      chk("mem_dstM", {24'b0, mem_dstM}, {24'b0, m.dstm});
      chk("cc", {29'b0, cc_zf, cc_sf, cc_of}, {29'b0, m_zf, m_sf, m_of});
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] ic, input logic [7:0] fn,
                       input logic [7:0] ra, input logic [7:0] rb,
                       input logic [31:0] va, input logic [31:0] vb,
                       input logic [31:0] vc);
    ex_icode = ic; ex_ifun = fn; ex_rA = ra; ex_rB = rb;
    ex_valA = va; ex_valB = vb; ex_valC = vc; ex_valP = 32'h1000 + {24'b0, ic};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1; mem_stall = 0; mem_bubble = 0; set_cc_inhibit = 0;
    drive(8'h06, 8'h00, 8'h01, 8'h02, 32'h11, 32'h22, 32'h33);
    step(); step();
    chk_en = 1;
    chk("rst_icode", {24'b0, mem_icode}, 32'h1);
    chk("rst_dstE", {24'b0, mem_dstE}, 32'hF);
    chk("rst_dstM", {24'b0, mem_dstM}, 32'hF);
    chk("rst_valE", mem_valE, 32'h0);
    chk("rst_cc", {29'b0, cc_zf, cc_sf, cc_of}, 32'b100);
    rst = 0;

    drive(8'h06, 8'h01, 8'h0F, 8'h03, 32'd5, 32'd5, 32'h0);
    step();
    chk("sub0_valE", mem_valE, 32'h0);
    chk("sub0_dstE", {24'b0, mem_dstE}, 32'h3);
    chk("sub0_zf", {31'b0, cc_zf}, 32'h1);

    drive(8'h06, 8'h01, 8'h0F, 8'h03, 32'h1, 32'h8000_0000, 32'h0);
    step();
    chk("subov_valE", mem_valE, 32'h7FFF_FFFF);
    chk("subov_cc", {29'b0, cc_zf, cc_sf, cc_of}, 32'b001);

    drive(8'h06, 8'h00, 8'h0F, 8'h03, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h0);
    step();
    chk("addov_valE", mem_valE, 32'hFFFF_FFFE);
    chk("addov_cc", {29'b0, cc_zf, cc_sf, cc_of}, 32'b011);

    drive(8'h07, 8'h02, 8'h0F, 8'h0F, 32'h0, 32'h0, 32'h2000);
    #1 chk("jl_cnd", {31'b0, ex_cnd}, 32'h0);
    drive(8'h07, 8'h01, 8'h0F, 8'h0F, 32'h0, 32'h0, 32'h2000);
    #1 chk("jle_cnd", {31'b0, ex_cnd}, 32'h0);
    drive(8'h07, 8'h04, 8'h0F, 8'h0F, 32'h0, 32'h0, 32'h2000);
    #1 chk("jne_cnd", {31'b0, ex_cnd}, 32'h1);
    step();

    drive(8'h06, 8'h03, 8'h0F, 8'h01, 32'h5, 32'h5, 32'h0);   // xor -> ZF=1
    step();
    drive(8'h02, 8'h03, 8'h01, 8'h02, 32'h77, 32'h0, 32'h0);  // cmove
    step();
    chk("cmove_dstE", {24'b0, mem_dstE}, 32'h2);
    chk("cmove_cnd", {31'b0, mem_cnd}, 32'h1);
    drive(8'h02, 8'h04, 8'h01, 8'h02, 32'h77, 32'h0, 32'h0);  // cmovne
    step();
    chk("cmovne_dstE", {24'b0, mem_dstE}, 32'hF);

    drive(8'h0A, 8'h00, 8'h03, 8'h0F, 32'h9, 32'h100, 32'h0);
    step();
    chk("push_valE", mem_valE, 32'hFC);
    chk("push_dstE", {24'b0, mem_dstE}, 32'h4);
    drive(8'h0B, 8'h00, 8'h06, 8'h0F, 32'h9, 32'h100, 32'h0);
    step();
    chk("pop_valE", mem_valE, 32'h104);
    chk("pop_dstE", {24'b0, mem_dstE}, 32'h4);
    chk("pop_dstM", {24'b0, mem_dstM}, 32'h6);

    set_cc_inhibit = 1;
    drive(8'h06, 8'h01, 8'h0F, 8'h05, 32'h1, 32'h0, 32'h0);   // 0-1 = FFFFFFFF
    step();
    set_cc_inhibit = 0;
    chk("inh_valE", mem_valE, 32'hFFFF_FFFF);
    chk("inh_cc", {29'b0, cc_zf, cc_sf, cc_of}, 32'b100);

    mem_stall = 1;
    drive(8'h06, 8'h00, 8'h0F, 8'h05, 32'h1, 32'h1, 32'h0);
    step(); step(); step();
    chk("stall_icode", {24'b0, mem_icode}, 32'h6);
    chk("stall_valE", mem_valE, 32'hFFFF_FFFF);
    chk("stall_cc", {29'b0, cc_zf, cc_sf, cc_of}, 32'b100);
    mem_stall = 0; mem_bubble = 1;
    step();
    chk("bub_icode", {24'b0, mem_icode}, 32'h1);
    chk("bub_valE", mem_valE, 32'h0);
    chk("bub_dstE", {24'b0, mem_dstE}, 32'hF);
    chk("bub_cc", {29'b0, cc_zf, cc_sf, cc_of}, 32'b000);
    mem_stall = 1;
    drive(8'h03, 8'h00, 8'h0F, 8'h01, 32'h0, 32'h0, 32'h55);
    step();
    chk("sb_icode", {24'b0, mem_icode}, 32'h1);
    mem_stall = 0; mem_bubble = 0;

    for (int i = 0; i < 1500; i++) begin
      drive(8'($urandom_range(0, 13)), 8'($urandom_range(0, 7)),
            8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
            pick(), pick(), pick());
      ex_valP = $urandom;
      if ($urandom_range(0, 3) == 0) ex_icode = 8'h06;
      mem_stall      = ($urandom_range(0, 9) == 0);
      mem_bubble     = ($urandom_range(0, 9) == 0);
      set_cc_inhibit = ($urandom_range(0, 7) == 0);
      rst            = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 0; mem_stall = 0; mem_bubble = 0; set_cc_inhibit = 0;
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
